alu_rs: RTL and testbench

//  Reservation station directly upstream of the single-cycle ALU. Holds dispatched ALU ops until both

---
 rtl/alu_rs_pkg.sv | 44 ++++
 rtl/alu_rs_age_matrix.sv | 53 +++++
 rtl/alu_rs.sv | 138 +++++++++++++
 tb/tb_alu_rs.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_rs_pkg                                                         |
// | Shared types for the ALU reservation station.                      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package alu_rs_pkg;

  localparam int ROB_W        = 5;
  localparam int ALU_RS_DEPTH = 4;

  typedef logic [ROB_W-1:0] rob_tag_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  typedef struct packed {
    alu_op_e     aluop;
    rob_tag_t    rob_tag;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } alu_entry_t;

  typedef struct packed {
    alu_entry_t payload;
    logic       rs1_ready;
    logic       rs2_ready;
    rob_tag_t   rs1_tag;
    rob_tag_t   rs2_tag;
  } alu_rs_entry_t;

endpackage
`default_nettype wire

// File: rtl/alu_rs_age_matrix.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_rs_age_matrix                                                  |
// | Pairwise age tracking; grants the oldest requesting slot.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module alu_rs_age_matrix #(
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             flush_i,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] grant_o
);

  // r_age[i][j] set means slot i is older than slot j
  logic [DEPTH-1:0] r_age [DEPTH];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc_i[i]) begin
            r_age[i][j] <= 1'b0;
          end else if (free_i[i] || free_i[j]) begin
            r_age[i][j] <= 1'b0;
          end else if (alloc_i[j]) begin
            r_age[i][j] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant_o[i] = req_i[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (req_i[j] && r_age[j][i]) grant_o[i] = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_rs.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_rs                                                             |
// | ALU reservation station: CDB wakeup, oldest-ready issue.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int  DEPTH = ALU_RS_DEPTH,
  parameter type AE    = alu_entry_t,
  parameter type RE    = alu_rs_entry_t
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       flush_i,
  input  logic                       dispatch_valid_i,
  output logic                       dispatch_ready_o,
  input  logic [$bits(RE)-1:0]       dispatch_i,
  input  logic                       cdb_valid_i,
  input  logic [ROB_W-1:0]           cdb_tag_i,
  input  logic [31:0]                cdb_val_i,
  output logic                       issue_valid_o,
  input  logic                       issue_ready_i,
  output logic [$bits(AE)-1:0]       issue_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int             CW      = $clog2(DEPTH+1);
  localparam logic [CW-1:0]  c_depth = CW'(DEPTH);

  logic [DEPTH-1:0] r_valid;
  RE                r_ent [DEPTH];
  logic [CW-1:0]    r_count;

  RE                w_din;
  logic [DEPTH-1:0] w_req;
  logic [DEPTH-1:0] w_grant;
  logic [DEPTH-1:0] w_free_oh;
  logic [DEPTH-1:0] w_alloc;
  logic [DEPTH-1:0] w_release;
  logic             w_dispatch_fire;
  logic             w_issue_fire;
  AE                w_issue;

  // The cdb_valid_i gate comes first so an undriven tag cannot leak into state.
  function automatic RE f_wake(input RE e, input logic v, input logic [ROB_W-1:0] t,
                               input logic [31:0] d);
    RE r;
    r = e;
    if (v && !e.rs1_ready && (e.rs1_tag == t)) begin
      r.rs1_ready       = 1'b1;
      r.payload.rs1_val = d;
    end
    if (v && !e.rs2_ready && (e.rs2_tag == t)) begin
      r.rs2_ready       = 1'b1;
      r.payload.rs2_val = d;
    end
    return r;
  endfunction

  assign w_din            = RE'(dispatch_i);
  assign dispatch_ready_o = !flush_i && (r_count < c_depth);
  assign w_dispatch_fire  = dispatch_valid_i && dispatch_ready_o;

  always_comb begin
    w_free_oh = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_oh    = '0;
        w_free_oh[i] = 1'b1;
      end
    end
  end

  assign w_alloc = w_dispatch_fire ? w_free_oh : '0;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_req[i] = r_valid[i] && r_ent[i].rs1_ready && r_ent[i].rs2_ready;
    end
  end

  alu_rs_age_matrix #(
    .DEPTH (DEPTH)
  ) u_age (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .flush_i  (flush_i),
    .alloc_i  (w_alloc),
    .free_i   (w_release),
    .req_i    (w_req),
    .grant_o  (w_grant)
  );

  assign issue_valid_o = (|w_req) && !flush_i;
  assign w_issue_fire  = issue_valid_o && issue_ready_i;
  assign w_release     = w_issue_fire ? w_grant : '0;

  always_comb begin
    w_issue = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) w_issue = r_ent[i].payload;
    end
  end

  assign issue_o = w_issue;
  assign count_o = r_count;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_valid <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc[i]) begin
          r_valid[i] <= 1'b1;
          r_ent[i]   <= f_wake(w_din, cdb_valid_i, cdb_tag_i, cdb_val_i);
        end else begin
          if (w_release[i]) r_valid[i] <= 1'b0;
          if (r_valid[i])   r_ent[i]   <= f_wake(r_ent[i], cdb_valid_i, cdb_tag_i, cdb_val_i);
        end
      end
      case ({w_dispatch_fire, w_issue_fire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_rs                                                          |
// | Scoreboard bench for the ALU reservation station.                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic                         clk_i = 1'b0;
  logic                         reset_ni;
  logic                         flush_i;
  logic                         dispatch_valid_i;
  logic                         dispatch_ready_o;
  alu_rs_entry_t                dispatch_i;
  logic                         cdb_valid_i;
  logic [ROB_W-1:0]             cdb_tag_i;
  logic [31:0]                  cdb_val_i;
  logic                         issue_valid_o;
  logic                         issue_ready_i;
  alu_entry_t                   issue_o;
  logic [$clog2(ALU_RS_DEPTH+1)-1:0] count_o;

  int         n_total = 0;
  int         n_bad   = 0;
  alu_entry_t sb [$];
  alu_entry_t r_exp;

  always #5 clk_i = ~clk_i;

  alu_rs u_dut (
    .clk_i            (clk_i),
    .reset_ni         (reset_ni),
    .flush_i          (flush_i),
    .dispatch_valid_i (dispatch_valid_i),
    .dispatch_ready_o (dispatch_ready_o),
    .dispatch_i       (dispatch_i),
    .cdb_valid_i      (cdb_valid_i),
    .cdb_tag_i        (cdb_tag_i),
    .cdb_val_i        (cdb_val_i),
    .issue_valid_o    (issue_valid_o),
    .issue_ready_i    (issue_ready_i),
    .issue_o          (issue_o),
    .count_o          (count_o)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic alu_rs_entry_t mk(input alu_op_e op, input logic [4:0] rob,
      input logic r1, input logic [4:0] t1, input logic [31:0] v1,
      input logic r2, input logic [4:0] t2, input logic [31:0] v2);
    alu_rs_entry_t e;
    e.payload.aluop   = op;
    e.payload.rob_tag = rob;
    e.payload.rs1_val = v1;
    e.payload.rs2_val = v2;
    e.rs1_ready = r1;
    e.rs2_ready = r2;
    e.rs1_tag   = t1;
    e.rs2_tag   = t2;
    return e;
  endfunction

  function automatic alu_entry_t ae(input alu_op_e op, input logic [4:0] rob,
                                    input logic [31:0] v1, input logic [31:0] v2);
    alu_entry_t a;
    a.aluop   = op;
    a.rob_tag = rob;
    a.rs1_val = v1;
    a.rs2_val = v2;
    return a;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_dispatch(input alu_rs_entry_t e);
    dispatch_valid_i = 1'b1;
    dispatch_i       = e;
    #1;
    chk("disp_rdy", dispatch_ready_o, 1'b1);
    tick();
    dispatch_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, sb.size(), 0);
    chk({tag, "_cnt"}, count_o, 0);
  endtask

  // Every fired issue must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (reset_ni && issue_valid_o && issue_ready_i) begin
      chk("sb_pending", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        r_exp = sb.pop_front();
        chk("issue_o", issue_o, r_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ni         = 1'b0;
    flush_i          = 1'b0;
    dispatch_valid_i = 1'b0;
    dispatch_i       = '0;
    cdb_valid_i      = 1'b0;
    cdb_tag_i        = 'x;
    cdb_val_i        = '0;
    issue_ready_i    = 1'b0;
    repeat (3) tick();
    chk("rst_cnt", count_o, 0);
    chk("rst_ivld", issue_valid_o, 1'b0);
    chk("rst_issue", issue_o, 0);
    chk("rst_drdy", dispatch_ready_o, 1'b1);
    reset_ni = 1'b1;
    tick();

    // 1: ready dispatch
    issue_ready_i = 1'b1;
    sb.push_back(ae(ALU_ADD, 5'd1, 32'd5, 32'd7));
    do_dispatch(mk(ALU_ADD, 5'd1, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd7));
    chk("t1_cnt1", count_o, 1);
    chk("t1_ivld", issue_valid_o, 1'b1);
    tick();
    chk("t1_cnt0", count_o, 0);

    // 2: wakeup from CDB, wrong tag ignored
    do_dispatch(mk(ALU_SUB, 5'd2, 1'b1, 5'd0, 32'd1, 1'b0, 5'd3, 32'hDEAD));
    chk("t2_wait", issue_valid_o, 1'b0);
    cdb_valid_i = 1'b1; cdb_tag_i = 5'd4; cdb_val_i = 32'h99;
    tick();
    cdb_valid_i = 1'b0; cdb_tag_i = 'x;
    chk("t2_tag4", issue_valid_o, 1'b0);
    sb.push_back(ae(ALU_SUB, 5'd2, 32'd1, 32'h10));
    cdb_valid_i = 1'b1; cdb_tag_i = 5'd3; cdb_val_i = 32'h10;
    tick();
    cdb_valid_i = 1'b0; cdb_tag_i = 'x;
    chk("t2_woke", issue_valid_o, 1'b1);
    drain("t2_drain");

    // 3: age order B, then A once woken, then C
    issue_ready_i = 1'b0;
    do_dispatch(mk(ALU_ADD, 5'd10, 1'b0, 5'd2, 32'hBAD, 1'b1, 5'd0, 32'd3));
    do_dispatch(mk(ALU_AND, 5'd11, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2));
    do_dispatch(mk(ALU_OR, 5'd12, 1'b1, 5'd0, 32'd4, 1'b1, 5'd0, 32'd5));
    chk("t3_sel_b", issue_o, ae(ALU_AND, 5'd11, 32'd1, 32'd2));
    chk("t3_cnt", count_o, 3);
    sb.push_back(ae(ALU_AND, 5'd11, 32'd1, 32'd2));
    sb.push_back(ae(ALU_ADD, 5'd10, 32'h55, 32'd3));
    sb.push_back(ae(ALU_OR, 5'd12, 32'd4, 32'd5));
    issue_ready_i = 1'b1;
    cdb_valid_i = 1'b1; cdb_tag_i = 5'd2; cdb_val_i = 32'h55;
    tick();
    cdb_valid_i = 1'b0; cdb_tag_i = 'x;
    drain("t3_drain");

    // 4: fill and back-pressure
    issue_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(ae(ALU_XOR, 5'(16 + i), 32'(i), 32'(i + 100)));
      do_dispatch(mk(ALU_XOR, 5'(16 + i), 1'b1, 5'd0, 32'(i), 1'b1, 5'd0, 32'(i + 100)));
    end
    chk("t4_cnt", count_o, 4);
    chk("t4_drdy", dispatch_ready_o, 1'b0);
    chk("t4_hold0", issue_o, ae(ALU_XOR, 5'd16, 32'd0, 32'd100));
    repeat (2) tick();
    chk("t4_hold2", issue_o, ae(ALU_XOR, 5'd16, 32'd0, 32'd100));
    chk("t4_cnt2", count_o, 4);
    issue_ready_i    = 1'b1;
    dispatch_valid_i = 1'b1;
    dispatch_i       = mk(ALU_SLL, 5'd30, 1'b1, 5'd0, 32'd9, 1'b1, 5'd0, 32'd9);
    #1;
    chk("t4_full_fire", dispatch_ready_o, 1'b0);
    tick();
    dispatch_valid_i = 1'b0;
    issue_ready_i    = 1'b0;
    #1;
    chk("t4_drdy_back", dispatch_ready_o, 1'b1);
    chk("t4_cnt3", count_o, 3);
    issue_ready_i = 1'b1;
    drain("t4_drain");

    // 5: dispatch coincides with matching CDB
    sb.push_back(ae(ALU_XOR, 5'd7, 32'hAB, 32'd1));
    cdb_valid_i = 1'b1; cdb_tag_i = 5'd6; cdb_val_i = 32'hAB;
    do_dispatch(mk(ALU_XOR, 5'd7, 1'b0, 5'd6, 32'hBAD, 1'b1, 5'd0, 32'd1));
    cdb_valid_i = 1'b0; cdb_tag_i = 'x;
    chk("t5_ivld", issue_valid_o, 1'b1);
    drain("t5_drain");

    // 6: flush, then asynchronous reset mid-operation
    issue_ready_i = 1'b0;
    for (int i = 0; i < 3; i++)
      do_dispatch(mk(ALU_ADD, 5'(20 + i), 1'b1, 5'd0, 32'(i), 1'b1, 5'd0, 32'(i)));
    chk("t6_cnt3", count_o, 3);
    flush_i = 1'b1;
    #1;
    chk("t6_fl_drdy", dispatch_ready_o, 1'b0);
    chk("t6_fl_ivld", issue_valid_o, 1'b0);
    tick();
    flush_i = 1'b0;
    #1;
    chk("t6_fl_cnt", count_o, 0);
    chk("t6_fl_ivld2", issue_valid_o, 1'b0);
    for (int i = 0; i < 2; i++)
      do_dispatch(mk(ALU_SUB, 5'(24 + i), 1'b1, 5'd0, 32'(i), 1'b1, 5'd0, 32'(i)));
    chk("t6_cnt2", count_o, 2);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("t6_rst_cnt", count_o, 0);
    chk("t6_rst_ivld", issue_valid_o, 1'b0);
    chk("t6_rst_issue", issue_o, 0);
    chk("t6_rst_drdy", dispatch_ready_o, 1'b1);
    tick();
    reset_ni = 1'b1;
    tick();
    chk("t6_post_cnt", count_o, 0);
    chk("t6_post_ivld", issue_valid_o, 1'b0);
    issue_ready_i = 1'b1;
    sb.push_back(ae(ALU_LUI, 5'd31, 32'd0, 32'h1234));
    do_dispatch(mk(ALU_LUI, 5'd31, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234));
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
